legv8_multicycle_cpu: RTL and testbench

Multicycle successor to the single-cycle LEGv8 core. It executes one instruction over several states of a control FSM, and talks to separate instruction and data memories through a req/ready handshake, so wait-states are tolerated. Datapath width is parametrised. CBNZ and sticky halt on unknown opcode are added to the existing subset. It sits at the top of the core hierarchy, below the SoC/testbench memories.

---
 rtl/legv8_pkg.sv | 43 ++++
 rtl/legv8_regfile.sv | 31 +++
 rtl/legv8_multicycle_cpu.sv | 154 +++++++++++++++
 tb/tb_legv8_multicycle_cpu.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared opcodes, FSM states, ALU control codes and instruction classes for the multicycle LEGv8 core.
package legv8_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_BAD} iclass_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_ORR = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    function automatic iclass_e classify(input logic [10:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? C_RTYPE :
               (op == OP_LDUR)     ? C_LDUR :
               (op == OP_STUR)     ? C_STUR :
               (op[10:3] == OP_CBZ)  ? C_CBZ  :
               (op[10:3] == OP_CBNZ) ? C_CBNZ :
               (op[10:5] == OP_B)    ? C_B    : C_BAD;
    endfunction

    function automatic logic [3:0] alu_ctrl(input logic [10:0] op);
        return (op == OP_SUB) ? ALU_SUB : (op == OP_AND) ? ALU_AND : (op == OP_ORR) ? ALU_ORR : ALU_ADD;
    endfunction

endpackage

// File: rtl/legv8_regfile.sv
// legv8_regfile: 31 GPRs plus hardwired XZR; two asynchronous reads, one synchronous write, cleared on reset.
module legv8_regfile
    import legv8_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [4:0]      ra_i,
    input  logic [4:0]      rb_i,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rda_o,
    output logic [XLEN-1:0] rdb_o
);

    logic [XLEN-1:0] regs_q [31];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < 31; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 5'd31) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rda_o = (ra_i == 5'd31) ? '0 : regs_q[ra_i];
    assign rdb_o = (rb_i == 5'd31) ? '0 : regs_q[rb_i];

endmodule

// File: rtl/legv8_multicycle_cpu.sv
// legv8_multicycle_cpu: multicycle LEGv8 subset core with req/ready instruction and data memory ports.
module legv8_multicycle_cpu
    import legv8_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock_i,
    input  logic            reset_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      state_o,
    output logic            halted_o
);

    state_e          state_q, state_d;
    iclass_e         cls_q, cls_d, cls_now;
    logic [31:0]     ir_q, ir_d;
    logic [3:0]      aluc_q, aluc_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [XLEN-1:0] daddr_q, daddr_d, wdata_q, wdata_d;
    logic            ireq_q, ireq_d, dreq_q, dreq_d, we_q, we_d, halted_q, halted_d;
    logic [XLEN-1:0] rf_a, rf_b, alu_y, off_b, off_cb, off_d;
    logic            taken;

    assign cls_now = classify(ir_q[31:21]);
    assign off_b   = {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    assign off_cb  = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    assign off_d   = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
    assign alu_y   = (aluc_q == ALU_AND) ? (a_q & b_q) : (aluc_q == ALU_ORR) ? (a_q | b_q) :
                     (aluc_q == ALU_SUB) ? (a_q - b_q) : (a_q + b_q);
    assign taken   = (cls_q == C_B) || (cls_q == C_CBZ && b_q == '0) || (cls_q == C_CBNZ && b_q != '0);

    // Reg2loc: stores and compare-branches read Rt on the second port instead of Rm.
    legv8_regfile #(.XLEN(XLEN)) u_rf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .ra_i    (ir_q[9:5]),
        .rb_i    ((cls_now inside {C_STUR, C_CBZ, C_CBNZ}) ? ir_q[4:0] : ir_q[20:16]),
        .we_i    (state_q == S_WB),
        .wa_i    (ir_q[4:0]),
        .wd_i    ((cls_q == C_LDUR) ? mdr_q : alu_q),
        .rda_o   (rf_a),
        .rdb_o   (rf_b)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cls_d   = cls_q;
        aluc_d  = aluc_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        daddr_d = daddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            S_FETCH: begin
                if (ireq_q && imem_ready_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d   = cls_now;
                aluc_d  = alu_ctrl(ir_q[31:21]);
                a_d     = rf_a;
                b_d     = rf_b;
                state_d = (cls_now == C_BAD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_d   = alu_y;
                pc_d    = taken ? pc_q + ((cls_q == C_B) ? off_b : off_cb) : pc_q + XLEN'(4);
                state_d = (cls_q == C_RTYPE) ? S_WB : (cls_q inside {C_LDUR, C_STUR}) ? S_MEM : S_FETCH;
                if (state_d == S_MEM) begin
                    daddr_d = a_q + off_d;
                    wdata_d = b_q;
                    we_d    = (cls_q == C_STUR);
                end
            end
            S_MEM: begin
                if (dreq_q && dmem_ready_i) begin
                    mdr_d   = dmem_rdata_i;
                    state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        ireq_d   = (state_d == S_FETCH);
        dreq_d   = (state_d == S_MEM);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            cls_q    <= C_RTYPE;
            aluc_q   <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            daddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            ireq_q   <= 1'b0;
            dreq_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cls_q    <= cls_d;
            aluc_q   <= aluc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            ireq_q   <= ireq_d;
            dreq_q   <= dreq_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req_o   = ireq_q;
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = dreq_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = daddr_q;
    assign dmem_wdata_o = wdata_q;
    assign pc_o         = pc_q;
    assign state_o      = state_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_legv8_multicycle_cpu.sv
// tb_legv8_multicycle_cpu: directed programs against behavioural instruction/data memories with configurable wait states.
module tb_legv8_multicycle_cpu;
    import legv8_pkg::*;

    logic        clock, reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [31:0] imem_rdata;
    logic [2:0]  st;

    int          n_cmp, n_err, iwait, dwait, icnt, dcnt;
    bit          dmem_manual;
    logic        man_dready;
    logic [31:0] imem [256];
    logic [63:0] dmem [logic [63:0]];

    legv8_multicycle_cpu #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clock_i(clock), .reset_i(reset),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
        .pc_o(pc), .state_o(st), .halted_o(halted)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder: answers requests after iwait/dwait stall cycles, changes only on the falling edge.
    initial begin
        imem_ready = 0; imem_rdata = '0; dmem_ready = 0; dmem_rdata = '0; icnt = 0; dcnt = 0;
        forever begin
            @(negedge clock);
            if (imem_req && !reset) begin
                if (icnt >= iwait) begin imem_ready = 1; imem_rdata = imem[imem_addr[9:2]]; end
                else begin imem_ready = 0; icnt++; end
            end else begin imem_ready = 0; icnt = 0; end
            if (dmem_manual) dmem_ready = man_dready;
            else if (dmem_req && !reset) begin
                if (dcnt >= dwait) begin
                    dmem_ready = 1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : '0;
                end else begin dmem_ready = 0; dcnt++; end
            end else begin dmem_ready = 0; dcnt = 0; end
        end
    end

    function automatic logic [31:0] r_ins(logic [10:0] op, int rm, int rn, int rd);
        return {op, 5'(rm), 6'b0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] d_ins(logic [10:0] op, int imm, int rn, int rt);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] cb_ins(logic [7:0] op, int off, int rt);
        return {op, 19'(off), 5'(rt)};
    endfunction
    function automatic logic [31:0] b_ins(int off);
        return {OP_B, 26'(off)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    task automatic wait_fetch(output logic [63:0] p, output int n);
        bit left, found;
        left  = !(st == 3'd0 && imem_req);
        found = 0;
        n     = 0;
        while (!found && n < 200) begin
            @(negedge clock);
            n++;
            if (st != 3'd0) left = 1;
            else if (left && imem_req) found = 1;
        end
        p = pc;
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_timeout: no new fetch after %0d cycles, want one", n);
        end
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 500) begin @(negedge clock); n++; end
        n_cmp++;
        if (halted !== 1'b1) begin n_err++; $display("FAIL halt_timeout: halted=%b want 1", halted); end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clock);
        n_cmp += 8;
        if (pc !== 64'h0)         begin n_err++; $display("FAIL reset_pc: got %0h want 0", pc); end
        if (st !== 3'd0)          begin n_err++; $display("FAIL reset_state: got %0d want 0", st); end
        if (imem_req !== 1'b0)    begin n_err++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        if (dmem_req !== 1'b0)    begin n_err++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
        if (dmem_we !== 1'b0)     begin n_err++; $display("FAIL reset_dmem_we: got %b want 0", dmem_we); end
        if (dmem_addr !== 64'h0)  begin n_err++; $display("FAIL reset_dmem_addr: got %0h want 0", dmem_addr); end
        if (dmem_wdata !== 64'h0) begin n_err++; $display("FAIL reset_dmem_wdata: got %0h want 0", dmem_wdata); end
        if (halted !== 1'b0)      begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        reset = 0;
    endtask

    task automatic test_rtype();
        logic [63:0] p;
        int n;
        clear_imem();
        imem[0] = d_ins(OP_LDUR, 0, 31, 2);
        imem[1] = d_ins(OP_LDUR, 8, 31, 3);
        imem[2] = r_ins(OP_ADD, 31, 31, 1);
        imem[3] = r_ins(OP_ADD, 3, 2, 4);
        imem[4] = d_ins(OP_STUR, 24, 31, 4);
        imem[5] = d_ins(OP_STUR, 32, 31, 1);
        dmem[0] = 5; dmem[8] = 7; dmem[24] = 0; dmem[32] = 64'hDEAD;
        iwait = 0; dwait = 0;
        do_reset();
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h0) begin n_err++; $display("FAIL first_fetch_pc: got %0h want 0", p); end
        if (imem_addr !== pc) begin n_err++; $display("FAIL imem_addr_eq_pc: got %0h want %0h", imem_addr, pc); end
        wait_fetch(p, n);
        n_cmp++;
        if (n !== 5) begin n_err++; $display("FAIL ldur_latency: got %0d want 5", n); end
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'hC) begin n_err++; $display("FAIL add_next_pc: got %0h want c", p); end
        if (n !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", n); end
        wait_halt();
        n_cmp += 3;
        if (dmem[24] !== 64'd12) begin n_err++; $display("FAIL add_x4: got %0h want c", dmem[24]); end
        if (dmem[32] !== 64'd0)  begin n_err++; $display("FAIL add_xzr_x1: got %0h want 0", dmem[32]); end
        if (pc !== 64'h18)       begin n_err++; $display("FAIL halt_pc_rtype: got %0h want 18", pc); end
    endtask

    task automatic test_mem_waits();
        logic [63:0] p;
        int n, rc, cyc;
        bit ok, left;
        clear_imem();
        imem[0] = d_ins(OP_LDUR, 8, 31, 4);
        imem[1] = d_ins(OP_STUR, 16, 31, 4);
        imem[2] = d_ins(OP_LDUR, 16, 31, 5);
        imem[3] = d_ins(OP_STUR, 40, 31, 5);
        dmem[8] = 12; dmem[16] = 0; dmem[40] = 0;
        iwait = 0; dwait = 3;
        do_reset();
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL ldur_wait_latency_1: got %0d want 8", n); end
        ok = 1; rc = 0; cyc = 0; left = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            cyc++;
            if (dmem_req) begin
                rc++;
                if (dmem_addr !== 64'd16 || dmem_wdata !== 64'd12 || dmem_we !== 1'b1) ok = 0;
            end
            if (st != 3'd0) left = 1;
            else if (left && imem_req) break;
        end
        n_cmp += 4;
        if (ok !== 1'b1) begin n_err++; $display("FAIL stur_stable: got %b want 1", ok); end
        if (rc !== 4)    begin n_err++; $display("FAIL stur_req_cycles: got %0d want 4", rc); end
        if (cyc !== 7)   begin n_err++; $display("FAIL stur_latency: got %0d want 7", cyc); end
        if (pc !== 64'h8) begin n_err++; $display("FAIL stur_next_pc: got %0h want 8", pc); end
        wait_fetch(p, n);
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL ldur_wait_latency: got %0d want 8", n); end
        wait_halt();
        n_cmp += 2;
        if (dmem[16] !== 64'd12) begin n_err++; $display("FAIL stur_data: got %0h want c", dmem[16]); end
        if (dmem[40] !== 64'd12) begin n_err++; $display("FAIL ldur_x5: got %0h want c", dmem[40]); end
        dwait = 0;
    endtask

    task automatic test_branches();
        logic [63:0] p;
        int n;
        clear_imem();
        imem[0]  = b_ins(8);
        imem[8]  = cb_ins(OP_CBZ, 3, 31);
        imem[11] = d_ins(OP_LDUR, 0, 31, 7);
        imem[12] = cb_ins(OP_CBNZ, 2, 7);
        imem[14] = cb_ins(OP_CBZ, 4, 7);
        dmem[0] = 5;
        iwait = 0;
        do_reset();
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h20) begin n_err++; $display("FAIL b_fwd_pc: got %0h want 20", p); end
        if (n !== 3)      begin n_err++; $display("FAIL b_latency: got %0d want 3", n); end
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h2C) begin n_err++; $display("FAIL cbz_taken_pc: got %0h want 2c", p); end
        if (n !== 3)      begin n_err++; $display("FAIL cbz_latency: got %0d want 3", n); end
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp++;
        if (p !== 64'h38) begin n_err++; $display("FAIL cbnz_taken_pc: got %0h want 38", p); end
        wait_fetch(p, n);
        n_cmp++;
        if (p !== 64'h3C) begin n_err++; $display("FAIL cbz_not_taken_pc: got %0h want 3c", p); end
        clear_imem();
        imem[0]  = b_ins(8);
        imem[8]  = cb_ins(OP_CBNZ, 3, 31);
        imem[9]  = b_ins(7);
        imem[16] = b_ins(-2);
        iwait = 1;
        do_reset();
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL b_wait_latency: got %0d want 4", n); end
        wait_fetch(p, n);
        n_cmp++;
        if (p !== 64'h24) begin n_err++; $display("FAIL cbnz_not_taken_pc: got %0h want 24", p); end
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h38) begin n_err++; $display("FAIL b_back_pc: got %0h want 38", p); end
        if (n !== 4)      begin n_err++; $display("FAIL b_back_latency: got %0d want 4", n); end
        iwait = 0;
    endtask

    task automatic test_sub_xzr();
        clear_imem();
        imem[0]  = d_ins(OP_LDUR, 0, 31, 2);
        imem[1]  = d_ins(OP_LDUR, 8, 31, 3);
        imem[2]  = d_ins(OP_LDUR, 16, 31, 11);
        imem[3]  = r_ins(OP_SUB, 2, 31, 6);
        imem[4]  = r_ins(OP_ADD, 2, 2, 31);
        imem[5]  = r_ins(OP_AND, 11, 3, 10);
        imem[6]  = r_ins(OP_ORR, 11, 3, 12);
        imem[7]  = d_ins(OP_STUR, 48, 31, 6);
        imem[8]  = d_ins(OP_STUR, 56, 31, 31);
        imem[9]  = d_ins(OP_STUR, 64, 31, 10);
        imem[10] = d_ins(OP_STUR, 72, 31, 12);
        dmem[0] = 1; dmem[8] = 64'hC; dmem[16] = 64'h6;
        dmem[48] = 0; dmem[56] = 1234; dmem[64] = 0; dmem[72] = 0;
        do_reset();
        wait_halt();
        n_cmp += 4;
        if (dmem[48] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sub_wrap: got %0h want ffffffffffffffff", dmem[48]); end
        if (dmem[56] !== 64'h0) begin n_err++; $display("FAIL xzr_read: got %0h want 0", dmem[56]); end
        if (dmem[64] !== 64'h4) begin n_err++; $display("FAIL and_result: got %0h want 4", dmem[64]); end
        if (dmem[72] !== 64'hE) begin n_err++; $display("FAIL orr_result: got %0h want e", dmem[72]); end
    endtask

    task automatic test_halt();
        logic [63:0] p;
        int n;
        bit req_seen;
        clear_imem();
        imem[0] = d_ins(OP_STUR, 88, 31, 10);
        imem[1] = r_ins(OP_ADD, 31, 31, 1);
        dmem[88] = 77;
        do_reset();
        wait_fetch(p, n);
        wait_fetch(p, n);
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h8) begin n_err++; $display("FAIL halt_fetch_pc: got %0h want 8", p); end
        if (dmem[88] !== 64'h0) begin n_err++; $display("FAIL gpr_reset_clear: got %0h want 0", dmem[88]); end
        @(negedge clock);
        @(negedge clock);
        n_cmp += 2;
        if (st !== 3'd5)    begin n_err++; $display("FAIL halt_state: got %0d want 5", st); end
        if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b want 1", halted); end
        req_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (imem_req || dmem_req || !halted) req_seen = 1;
        end
        n_cmp += 2;
        if (req_seen !== 1'b0) begin n_err++; $display("FAIL halt_quiet: got %b want 0", req_seen); end
        if (pc !== 64'h8)      begin n_err++; $display("FAIL halt_pc: got %0h want 8", pc); end
        reset = 1;
        @(negedge clock);
        n_cmp += 3;
        if (pc !== 64'h0)     begin n_err++; $display("FAIL halt_reset_pc: got %0h want 0", pc); end
        if (halted !== 1'b0)  begin n_err++; $display("FAIL halt_reset_flag: got %b want 0", halted); end
        if (st !== 3'd0)      begin n_err++; $display("FAIL halt_reset_state: got %0d want 0", st); end
        reset = 0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] p;
        int n;
        clear_imem();
        imem[0] = d_ins(OP_STUR, 80, 31, 31);
        dmem[80] = 55;
        man_dready = 0;
        dmem_manual = 1;
        do_reset();
        n = 0;
        while (!dmem_req && n < 20) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        n_cmp++;
        if (dmem_req !== 1'b1) begin n_err++; $display("FAIL mid_req_held: got %b want 1", dmem_req); end
        reset = 1;
        man_dready = 1;
        @(negedge clock);
        n_cmp++;
        if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop: got %b want 0", dmem_req); end
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        n_cmp += 4;
        if (dmem_req !== 1'b0) begin n_err++; $display("FAIL late_ready_ignored: got %b want 0", dmem_req); end
        if (st !== 3'd0)       begin n_err++; $display("FAIL post_reset_state: got %0d want 0", st); end
        if (imem_req !== 1'b1) begin n_err++; $display("FAIL post_reset_fetch: got %b want 1", imem_req); end
        if (imem_addr !== 64'h0) begin n_err++; $display("FAIL post_reset_addr: got %0h want 0", imem_addr); end
        man_dready = 0;
        dmem_manual = 0;
        wait_fetch(p, n);
        n_cmp += 2;
        if (p !== 64'h4)        begin n_err++; $display("FAIL post_reset_stur_pc: got %0h want 4", p); end
        if (dmem[80] !== 64'h0) begin n_err++; $display("FAIL post_reset_stur_data: got %0h want 0", dmem[80]); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; iwait = 0; dwait = 0;
        dmem_manual = 0; man_dready = 0; reset = 1;
        clear_imem();
        test_reset();
        test_rtype();
        test_mem_waits();
        test_branches();
        test_sub_xzr();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
